// File: rtl/dmem_if.sv
// dmem_if: execute-stage memory port (address, store data, store strobe, read data).
// master drives mem_addr/mem_in/mem_we and samples mem_out; slave does the reverse.
interface dmem_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_in;
  logic        mem_we;
  logic [15:0] mem_out;
  modport master (output mem_addr, mem_in, mem_we, input mem_out);
  modport slave (input mem_addr, mem_in, mem_we, output mem_out);
endinterface

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder with word RAM and an I/O page (GPIO, cycle counter, timer, status, ctrl).
// Ports: clk, rst_n (sync, active-low); bus (dmem_if.slave, combinational read, write at edge);
// gpio_in (async inputs), gpio_out (GPIO_OUT reg), irq (STATUS[0] & CTRL[0]), err (STATUS[1]).
module dmem_resp #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_if.slave       bus,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic        irq,
  output logic        err
);
  logic [15:0] ram [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic [15:0] off, io_rd;
  logic is_ram, is_io, bad_wr, match;
  logic [1:0] clr;
  logic [15:0] gpio_out_q, gpio_out_d, sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0] cycle_q, cycle_d, cmp_q, cmp_d;
  logic [1:0] status_q, status_d, ctrl_q, ctrl_d;
  assign idx = bus.mem_addr[DEPTH_LOG2-1:0];
  always_comb begin
    off = bus.mem_addr - IO_BASE;
    is_ram = (bus.mem_addr >> DEPTH_LOG2) == 16'd0;
    is_io = bus.mem_addr >= IO_BASE && off < 16'd6;
    // writes to read-only registers count as access errors, same as unmapped ones
    bad_wr = bus.mem_we && !is_ram && !(is_io && off != 16'd1 && off != 16'd2);
    // compare uses pre-increment cycle and pre-write ctrl
    match = ctrl_q[1] && cycle_q == cmp_q;
    clr = (bus.mem_we && is_io && off == 16'd4) ? bus.mem_in[1:0] : 2'b00;
    // set terms are OR-ed after the clear so a same-cycle set wins
    status_d = (status_q & ~clr) | {bad_wr, match};
    gpio_out_d = (bus.mem_we && is_io && off == 16'd0) ? bus.mem_in : gpio_out_q;
    cmp_d = (bus.mem_we && is_io && off == 16'd3) ? bus.mem_in : cmp_q;
    ctrl_d = (bus.mem_we && is_io && off == 16'd5) ? bus.mem_in[1:0] : ctrl_q;
    cycle_d = cycle_q + 16'd1;
    sync1_d = gpio_in;
    sync2_d = sync1_q;
    io_rd = off == 16'd0 ? gpio_out_q :
            off == 16'd1 ? sync2_q :
            off == 16'd2 ? cycle_q :
            off == 16'd3 ? cmp_q :
            off == 16'd4 ? {14'd0, status_q} : {14'd0, ctrl_q};
    bus.mem_out = is_ram ? ram[idx] : is_io ? io_rd : 16'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_out_q <= 16'd0;
      sync1_q <= 16'd0;
      sync2_q <= 16'd0;
      cycle_q <= 16'd0;
      cmp_q <= 16'hFFFF;
      status_q <= 2'd0;
      ctrl_q <= 2'd0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cycle_q <= cycle_d;
      cmp_q <= cmp_d;
      status_q <= status_d;
      ctrl_q <= ctrl_d;
    end
  end
  // RAM contents survive reset; only the write pending during reset is dropped
  always_ff @(posedge clk) begin
    if (rst_n && bus.mem_we && is_ram) ram[idx] <= bus.mem_in;
  end
  assign gpio_out = gpio_out_q;
  assign irq = status_q[0] & ctrl_q[0];
  assign err = status_q[1];
endmodule
